// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates the branch condition, computes the correct next PC,
// flags mispredictions, trains a 2-bit bimodal predictor and keeps branch statistics.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  input  logic             res_valid,
  input  logic             branch_en,
  input  logic             stall,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [XLEN-1:0]  imm,
  input  logic [2:0]       func3,
  input  logic             pred_in,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] res_idx;
  logic             accept;
  logic             legal;
  logic             cond_taken;
  logic             mispredict;
  logic [XLEN-1:0]  next_pc;
  logic             unused_lookup_bits;

  assign lookup_idx         = lookup_pc[IDX_W+1:2];
  assign res_idx            = res_pc[IDX_W+1:2];
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  // Reads the table before this cycle's training write lands.
  assign lookup_taken = bht[lookup_idx][1];

  assign accept = res_valid & branch_en & ~stall;
  assign legal  = (func3[2:1] != 2'b01);

  always_comb begin
    cond_taken = 1'b0;
    case (func3)
      3'b000:  cond_taken = (op_a == op_b);
      3'b001:  cond_taken = (op_a != op_b);
      3'b100:  cond_taken = ($signed(op_a) <  $signed(op_b));
      3'b101:  cond_taken = ($signed(op_a) >= $signed(op_b));
      3'b110:  cond_taken = (op_a <  op_b);
      3'b111:  cond_taken = (op_a >= op_b);
      default: cond_taken = 1'b0;
    endcase
  end

  assign mispredict = legal & (cond_taken != pred_in);
  assign next_pc    = cond_taken ? (res_pc + imm) : (res_pc + XLEN'(4));

  // Stall freezes the result but drops flush so a redirect is issued only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
      out_next_pc    <= '0;
      flush          <= 1'b0;
    end else if (stall) begin
      flush <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_taken      <= cond_taken;
      out_mispredict <= mispredict;
      out_illegal    <= ~legal;
      out_next_pc    <= next_pc;
      flush          <= mispredict;
    end else begin
      out_valid <= 1'b0;
      flush     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept && legal) begin
      if (cond_taken && (bht[res_idx] != 2'b11)) begin
        bht[res_idx] <= bht[res_idx] + 2'b01;
      end else if (!cond_taken && (bht[res_idx] != 2'b00)) begin
        bht[res_idx] <= bht[res_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (accept && legal) begin
      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a cycle-level reference model compared every
// cycle, plus directed vectors with literal expectations; a CNT_W=2 copy exercises saturation.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        res_valid;
  logic        branch_en;
  logic        stall;
  logic [31:0] res_pc;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm;
  logic [2:0]  func3;
  logic        pred_in;

  logic        lookup_taken, out_valid, out_taken, out_mispredict, out_illegal, flush;
  logic [31:0] out_next_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        s_lookup_taken, s_valid, s_taken, s_mispredict, s_illegal, s_flush;
  logic [31:0] s_next_pc;
  logic [1:0]  s_branch_cnt, s_mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit      m_ready = 0;
  bit      m_valid, m_taken, m_mis, m_illegal, m_flush, m_pc_known;
  longint  m_pc;
  int      m_bht [16];
  longint  m_bcnt, m_mcnt;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .res_valid(res_valid), .branch_en(branch_en), .stall(stall), .res_pc(res_pc),
    .op_a(op_a), .op_b(op_b), .imm(imm), .func3(func3), .pred_in(pred_in),
    .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_next_pc(out_next_pc), .flush(flush),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_taken(s_lookup_taken),
    .res_valid(res_valid), .branch_en(branch_en), .stall(stall), .res_pc(res_pc),
    .op_a(op_a), .op_b(op_b), .imm(imm), .func3(func3), .pred_in(pred_in),
    .out_valid(s_valid), .out_taken(s_taken), .out_mispredict(s_mispredict),
    .out_illegal(s_illegal), .out_next_pc(s_next_pc), .flush(s_flush),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit model_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000:  return ua == ub;
      3'b001:  return ua != ub;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return ua < ub;
      3'b111:  return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sat(input longint v, input longint vmax);
    return (v > vmax) ? vmax : v;
  endfunction

  task automatic model_step();
    int  idx;
    bit  t;
    idx = int'((res_pc >> 2) % 16);
    if (rst) begin
      m_ready = 1; m_valid = 0; m_taken = 0; m_mis = 0; m_illegal = 0; m_flush = 0;
      m_pc = 0; m_pc_known = 1; m_bcnt = 0; m_mcnt = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
    end else if (stall) begin
      m_flush = 0;
    end else if (res_valid && branch_en) begin
      m_valid = 1;
      if (func3 == 3'b010 || func3 == 3'b011) begin
        m_taken = 0; m_illegal = 1; m_mis = 0; m_flush = 0;
        m_pc_known = 0;
      end else begin
        t = model_taken(func3, op_a, op_b);
        m_taken = t; m_illegal = 0;
        m_mis = (t != pred_in);
        m_flush = m_mis;
        m_pc = (longint'(res_pc) + (t ? longint'(imm) : 64'd4)) & 64'hFFFF_FFFF;
        m_pc_known = 1;
        if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        m_bcnt++;
        if (m_mis) m_mcnt++;
      end
    end else begin
      m_valid = 0;
      m_flush = 0;
    end
  endtask

  // Advance the model on each edge and compare both instances just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    if (m_ready) begin
      checkOutput("lookup_taken", lookup_taken, m_bht[(lookup_pc >> 2) % 16] >= 2);
      checkOutput("out_valid", out_valid, m_valid);
      checkOutput("out_taken", out_taken, m_taken);
      checkOutput("out_mispredict", out_mispredict, m_mis);
      checkOutput("out_illegal", out_illegal, m_illegal);
      checkOutput("flush", flush, m_flush);
      if (m_pc_known) checkOutput("out_next_pc", out_next_pc, m_pc);
      checkOutput("branch_cnt", branch_cnt, sat(m_bcnt, 65535));
      checkOutput("mispred_cnt", mispred_cnt, sat(m_mcnt, 65535));
      checkOutput("small_valid", s_valid, m_valid);
      checkOutput("small_flush", s_flush, m_flush);
      checkOutput("small_lookup", s_lookup_taken, m_bht[(lookup_pc >> 2) % 16] >= 2);
      checkOutput("small_branch_cnt", s_branch_cnt, sat(m_bcnt, 3));
      checkOutput("small_mispred_cnt", s_mispred_cnt, sat(m_mcnt, 3));
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic be, input logic st,
                               input logic [2:0] f, input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] im, input logic pr);
    @(negedge clk);
    rst = r; res_valid = v; branch_en = be; stall = st; func3 = f;
    res_pc = pc; op_a = a; op_b = b; imm = im; pred_in = pr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; lookup_pc = 32'h40; res_valid = 0; branch_en = 0; stall = 0;
    res_pc = 0; op_a = 0; op_b = 0; imm = 0; func3 = 0; pred_in = 0;

    applyStimulus(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_next_pc", out_next_pc, 0);
    checkOutput("reset_branch_cnt", branch_cnt, 0);
    checkOutput("reset_lookup", lookup_taken, 0);

    // Signed vs unsigned less-than on the same operands
    applyStimulus(0, 1, 1, 0, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 0);
    checkOutput("slt_taken", out_taken, 1);
    checkOutput("slt_next_pc", out_next_pc, 32'h120);
    checkOutput("slt_mispredict", out_mispredict, 1);
    checkOutput("slt_flush", flush, 1);
    checkOutput("slt_mispred_cnt", mispred_cnt, 1);
    applyStimulus(0, 1, 1, 0, 3'b110, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 0);
    checkOutput("ult_taken", out_taken, 0);
    checkOutput("ult_next_pc", out_next_pc, 32'h104);
    checkOutput("ult_flush", flush, 0);

    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0);
    checkOutput("idle_valid", out_valid, 0);
    checkOutput("idle_hold_pc", out_next_pc, 32'h104);

    // Predictor training at index 0
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 3'b000, 32'h40, 5, 5, 32'h10, 0);
      checkOutput("bht_train_taken", lookup_taken, 1);
    end
    checkOutput("beq_next_pc", out_next_pc, 32'h50);
    applyStimulus(0, 1, 1, 0, 3'b000, 32'h40, 5, 6, 32'h10, 1);
    checkOutput("bht_nt1", lookup_taken, 1);
    applyStimulus(0, 1, 1, 0, 3'b000, 32'h40, 5, 6, 32'h10, 1);
    checkOutput("bht_nt2", lookup_taken, 0);

    // Lookup and update at the same index in the same cycle
    @(negedge clk);
    rst = 0; res_valid = 1; branch_en = 1; stall = 0; func3 = 3'b000;
    res_pc = 32'h40; op_a = 9; op_b = 9; imm = 32'h10; pred_in = 1;
    #1;
    checkOutput("same_idx_pre", lookup_taken, 0);
    @(posedge clk);
    #2;
    checkOutput("same_idx_post", lookup_taken, 1);

    // PC wrap-around
    applyStimulus(0, 1, 1, 0, 3'b001, 32'hFFFF_FFFC, 3, 3, 32'h8, 0);
    checkOutput("wrap_nt_pc", out_next_pc, 32'h0);
    applyStimulus(0, 1, 1, 0, 3'b001, 32'hFFFF_FFFC, 3, 4, 32'h8, 1);
    checkOutput("wrap_t_pc", out_next_pc, 32'h4);

    // Accept then stall for three cycles
    applyStimulus(0, 1, 1, 0, 3'b000, 32'h200, 1, 1, 32'h40, 0);
    checkOutput("pre_stall_flush", flush, 1);
    checkOutput("pre_stall_pc", out_next_pc, 32'h240);
    checkOutput("pre_stall_bcnt", branch_cnt, 11);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 1, 3'b000, 32'h300, 1, 1, 32'h8, 0);
      checkOutput("stall_flush", flush, 0);
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_pc", out_next_pc, 32'h240);
      checkOutput("stall_bcnt", branch_cnt, 11);
      checkOutput("stall_mcnt", mispred_cnt, 7);
    end
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    checkOutput("post_stall_valid", out_valid, 0);

    // Signed vs unsigned greater-or-equal
    applyStimulus(0, 1, 1, 0, 3'b101, 32'h1000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 1);
    checkOutput("sge_taken", out_taken, 0);
    checkOutput("sge_next_pc", out_next_pc, 32'h1004);
    applyStimulus(0, 1, 1, 0, 3'b111, 32'h1000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 1);
    checkOutput("uge_taken", out_taken, 1);
    checkOutput("uge_next_pc", out_next_pc, 32'h1010);
    checkOutput("uge_bcnt", branch_cnt, 13);

    // Illegal conditions
    applyStimulus(0, 1, 1, 0, 3'b011, 32'h80, 7, 7, 32'h8, 1);
    checkOutput("ill011_illegal", out_illegal, 1);
    checkOutput("ill011_taken", out_taken, 0);
    checkOutput("ill011_flush", flush, 0);
    checkOutput("ill011_bcnt", branch_cnt, 13);
    checkOutput("small_sat_bcnt", s_branch_cnt, 3);
    applyStimulus(0, 1, 1, 0, 3'b010, 32'h80, 7, 7, 32'h8, 0);
    checkOutput("ill010_illegal", out_illegal, 1);

    applyStimulus(0, 1, 0, 0, 3'b000, 32'h80, 7, 7, 32'h8, 0);
    checkOutput("no_branch_en_valid", out_valid, 0);
    checkOutput("no_branch_en_bcnt", branch_cnt, 13);

    // Reset beats an accepting edge, then reset beats stall
    applyStimulus(1, 1, 1, 0, 3'b000, 32'h40, 1, 1, 32'h4, 0);
    checkOutput("rst_accept_bcnt", branch_cnt, 0);
    checkOutput("rst_accept_lookup", lookup_taken, 0);
    checkOutput("rst_accept_valid", out_valid, 0);
    applyStimulus(0, 1, 1, 0, 3'b000, 32'h40, 1, 1, 32'h4, 0);
    checkOutput("after_rst_flush", flush, 1);
    applyStimulus(1, 1, 1, 1, 3'b000, 32'h40, 1, 1, 32'h4, 0);
    checkOutput("rst_stall_valid", out_valid, 0);
    checkOutput("rst_stall_flush", flush, 0);
    checkOutput("rst_stall_bcnt", branch_cnt, 0);

    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
